// File: rtl/vpu_timing_pkg.sv
// Shared PAL timing constants and line-class type for the VPU sync generator.
package vpu_timing_pkg;

    localparam int unsigned CNT_W = 9;

    localparam int unsigned H_TOTAL_DEF     = 512;
    localparam int unsigned H_SYNC_DEF      = 38;
    localparam int unsigned H_EQ_DEF        = 19;
    localparam int unsigned H_VIS_START_DEF = 96;
    localparam int unsigned H_VIS_END_DEF   = 480;
    localparam int unsigned V_TOTAL_DEF     = 312;
    localparam int unsigned V_VIS_START_DEF = 40;
    localparam int unsigned V_VIS_END_DEF   = 296;

    // Lines 0..2 carry broad pulses, 3..4 and the last three lines carry equalizing pulses.
    localparam int unsigned BROAD_LINES   = 3;
    localparam int unsigned POST_EQ_LINES = 2;
    localparam int unsigned PRE_EQ_LINES  = 3;

    typedef enum logic [1:0] {
        BROAD,
        POST_EQ,
        PRE_EQ,
        NORMAL
    } line_class_e;

endpackage

// File: rtl/vpu_csync_decode.sv
// Combinational decode of a (cntHS, cntVS) position into line class and sync/window levels.
module vpu_csync_decode
    import vpu_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_EQ        = H_EQ_DEF,
    parameter int unsigned H_VIS_START = H_VIS_START_DEF,
    parameter int unsigned H_VIS_END   = H_VIS_END_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned V_VIS_START = V_VIS_START_DEF,
    parameter int unsigned V_VIS_END   = V_VIS_END_DEF
) (
    input  logic [CNT_W-1:0] h_pos,
    input  logic [CNT_W-1:0] v_pos,
    output line_class_e      line_class,
    output logic             hsync,
    output logic             sync,
    output logic             line_visible,
    output logic             vblank
);

    // One extra bit so that H_TOTAL = 512 and H_VIS_END = 512 stay representable.
    localparam int unsigned XW = CNT_W + 1;

    localparam logic [XW-1:0] HALF_C       = XW'(H_TOTAL / 2);
    localparam logic [XW-1:0] HS_C         = XW'(H_SYNC);
    localparam logic [XW-1:0] HEQ_C        = XW'(H_EQ);
    localparam logic [XW-1:0] BROAD_LOW_C  = XW'(H_TOTAL / 2 - H_SYNC);
    localparam logic [XW-1:0] HVS_C        = XW'(H_VIS_START);
    localparam logic [XW-1:0] HVE_C        = XW'(H_VIS_END);
    localparam logic [XW-1:0] VVS_C        = XW'(V_VIS_START);
    localparam logic [XW-1:0] VVE_C        = XW'(V_VIS_END);
    localparam logic [XW-1:0] BROAD_END_C  = XW'(BROAD_LINES);
    localparam logic [XW-1:0] POST_END_C   = XW'(BROAD_LINES + POST_EQ_LINES);
    localparam logic [XW-1:0] PRE_START_C  = XW'(V_TOTAL - PRE_EQ_LINES);

    logic [XW-1:0] h_ext;
    logic [XW-1:0] v_ext;
    logic [XW-1:0] half_pos;

    always_comb begin
        h_ext    = {1'b0, h_pos};
        v_ext    = {1'b0, v_pos};
        // Position within the current half line; broad and EQ pulses repeat every half line.
        half_pos = (h_ext >= HALF_C) ? (h_ext - HALF_C) : h_ext;

        if (v_ext < BROAD_END_C) begin
            line_class = BROAD;
        end else if (v_ext < POST_END_C) begin
            line_class = POST_EQ;
        end else if (v_ext >= PRE_START_C) begin
            line_class = PRE_EQ;
        end else begin
            line_class = NORMAL;
        end

        sync = 1'b1;
        unique case (line_class)
            BROAD:   sync = !(half_pos < BROAD_LOW_C);
            POST_EQ: sync = !(half_pos < HEQ_C);
            PRE_EQ:  sync = !(half_pos < HEQ_C);
            NORMAL:  sync = !(h_ext < HS_C);
        endcase

        hsync        = (h_ext < HS_C);
        vblank       = (v_ext < VVS_C) || (v_ext >= VVE_C);
        line_visible = !vblank && (h_ext >= HVS_C) && (h_ext < HVE_C);
    end

endmodule

// File: rtl/vpu_sync_gen.sv
// PAL progressive timing generator: pixel/line counters plus registered sync and window outputs.
module vpu_sync_gen
    import vpu_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_EQ        = H_EQ_DEF,
    parameter int unsigned H_VIS_START = H_VIS_START_DEF,
    parameter int unsigned H_VIS_END   = H_VIS_END_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned V_VIS_START = V_VIS_START_DEF,
    parameter int unsigned V_VIS_END   = V_VIS_END_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cntHS,
    output logic [CNT_W-1:0] cntVS,
    output logic             hsync,
    output logic             sync,
    output logic             line_visible,
    output logic             line_even,
    output logic             vblank,
    output logic             frame_start
);

    generate
        if (!((H_TOTAL % 2 == 0) && (H_TOTAL <= 512) && (V_TOTAL <= 512)
              && (H_SYNC < H_TOTAL / 2 - H_SYNC) && (H_EQ < H_SYNC)
              && (H_VIS_START >= H_SYNC) && (H_VIS_END <= H_TOTAL)
              && (V_VIS_START >= 5) && (V_VIS_START < V_VIS_END)
              && (V_VIS_END <= V_TOTAL - 3))) begin : g_bad_timing
            $error("vpu_sync_gen: illegal timing parameter set");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] cnt_hs_q, cnt_hs_d;
    logic [CNT_W-1:0] cnt_vs_q, cnt_vs_d;
    logic             hsync_q, hsync_d;
    logic             sync_q, sync_d;
    logic             line_visible_q, line_visible_d;
    logic             line_even_q, line_even_d;
    logic             vblank_q, vblank_d;
    logic             frame_start_q, frame_start_d;
    line_class_e      line_class;

    always_comb begin
        cnt_hs_d = cnt_hs_q + 1'b1;
        cnt_vs_d = cnt_vs_q;
        if (cnt_hs_q == H_LAST_C) begin
            cnt_hs_d = '0;
            cnt_vs_d = (cnt_vs_q == V_LAST_C) ? '0 : (cnt_vs_q + 1'b1);
        end
    end

    // Decoding the next-state position keeps every registered output aligned with the counters.
    vpu_csync_decode #(
        .H_TOTAL     (H_TOTAL),
        .H_SYNC      (H_SYNC),
        .H_EQ        (H_EQ),
        .H_VIS_START (H_VIS_START),
        .H_VIS_END   (H_VIS_END),
        .V_TOTAL     (V_TOTAL),
        .V_VIS_START (V_VIS_START),
        .V_VIS_END   (V_VIS_END)
    ) u_decode (
        .h_pos        (cnt_hs_d),
        .v_pos        (cnt_vs_d),
        .line_class   (line_class),
        .hsync        (hsync_d),
        .sync         (sync_d),
        .line_visible (line_visible_d),
        .vblank       (vblank_d)
    );

    always_comb begin
        line_even_d   = ~cnt_vs_d[0];
        frame_start_d = (cnt_hs_d == '0) && (cnt_vs_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_hs_q       <= '0;
            cnt_vs_q       <= '0;
            hsync_q        <= 1'b0;
            sync_q         <= 1'b1;
            line_visible_q <= 1'b0;
            line_even_q    <= 1'b0;
            vblank_q       <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            cnt_hs_q       <= cnt_hs_d;
            cnt_vs_q       <= cnt_vs_d;
            hsync_q        <= hsync_d;
            sync_q         <= sync_d;
            line_visible_q <= line_visible_d;
            line_even_q    <= line_even_d;
            vblank_q       <= vblank_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign cntHS        = cnt_hs_q;
    assign cntVS        = cnt_vs_q;
    assign hsync        = hsync_q;
    assign sync         = sync_q;
    assign line_visible = line_visible_q;
    assign line_even    = line_even_q;
    assign vblank       = vblank_q;
    assign frame_start  = frame_start_q;

endmodule

// File: doc/vpu_sync_gen.md
Name: vpu_sync_gen

Overview:
- PAL video timing generator driving the VPU pixel pipeline and the PAL encoder.
- Produces the horizontal and vertical counters, the line-start strobe, composite sync with broad and equalizing pulses, the visible window and line parity.
- Runs on the pixel clock.
- Progressive 312-line frame. No interlace.

Parameters:
H_TOTAL, 512, pixel clocks per line (64 us at 8 MHz); must be even
H_SYNC, 38, normal line-sync tip width in clocks
H_EQ, 19, equalizing pulse width in clocks
H_VIS_START, 96, first visible cntHS
H_VIS_END, 480, first non-visible cntHS after the visible span
V_TOTAL, 312, lines per frame
V_VIS_START, 40, first visible line
V_VIS_END, 296, first non-visible line after the visible span

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
cntHS  out  9  horizontal position, 0..H_TOTAL-1
cntVS  out  9  line number, 0..V_TOTAL-1
hsync  out  1  high during cntHS < H_SYNC; downstream uses it to reset pixel counters
sync  out  1  composite sync, active-low (0 = sync tip)
line_visible  out  1  high inside the visible window (both axes)
line_even  out  1  equals ~cntVS[0]; PAL phase alternation
vblank  out  1  high when cntVS < V_VIS_START or cntVS >= V_VIS_END
frame_start  out  1  one-clock pulse at cntHS=0, cntVS=0

Behaviour:
- Reset (rst low, async):
  - cntHS=0, cntVS=0
  - hsync=0, sync=1, line_visible=0, line_even=0, vblank=1, frame_start=0
- Counting:
  - cntHS increments every clock.
  - At H_TOTAL-1, cntHS wraps to 0 and cntVS increments in the same edge.
  - At cntVS=V_TOTAL-1 with cntHS=H_TOTAL-1, both wrap to 0.
- Output timing:
  - All outputs are registered and decoded from the next-state counter values.
  - Every output is therefore aligned with the cntHS/cntVS presented in the same cycle, with zero relative latency.
  - The first edge after reset release presents (1,0) with matching decode.
  - The (0,0) decode is first seen one frame later; frame_start first fires after one full frame.
- Line classes (HALF = H_TOTAL/2, p = cntHS mod HALF):
  - BROAD: cntVS 0..2. sync=0 when p < HALF-H_SYNC.
  - POST_EQ: cntVS 3..4. sync=0 when p < H_EQ.
  - PRE_EQ: cntVS V_TOTAL-3..V_TOTAL-1. sync=0 when p < H_EQ.
  - NORMAL: all other lines. sync=0 when cntHS < H_SYNC.
- hsync:
  - Driven on every line, including BROAD and EQ lines, for cntHS < H_SYNC.
  - It is independent of sync shaping.
- line_visible:
  - Set when V_VIS_START <= cntVS < V_VIS_END and H_VIS_START <= cntHS < H_VIS_END.
  - Always 0 on BROAD, EQ and blank lines.
- Parameter legality (elaboration-time assertion):
  - H_SYNC < HALF-H_SYNC
  - H_EQ < H_SYNC
  - H_VIS_START >= H_SYNC
  - H_VIS_END <= H_TOTAL
  - 5 <= V_VIS_START < V_VIS_END <= V_TOTAL-3
  - H_TOTAL <= 512, V_TOTAL <= 512
- Reset mid-frame: immediate return to reset values. The sequence restarts exactly as after power-on, with no partial pulse.
- No CPU register interface. Timing is fixed by parameters.

Decomposition:
- Package vpu_timing_pkg:
  - default timing constants
  - line-class enumeration: BROAD, POST_EQ, PRE_EQ, NORMAL
  - 9-bit counter width constant
- One sub-module, vpu_csync_decode:
  - combinational map of (next cntHS, next cntVS) to line class and sync/hsync/line_visible/vblank levels
  - instantiated once, feeding the output registers.
- Top level holds the counters and output flops.

Test Plan:
- Reset hold, then release -> all outputs at reset values during reset; first cycle cntHS=1, cntVS=0, sync=0 (BROAD), hsync=1.
- Line 100 scan -> hsync=1 and sync=0 exactly for cntHS 0..37; line_visible=1 exactly for cntHS 96..479; line_even=1.
- Wraps: cntHS=511 on line 100 -> next cycle cntHS=0, cntVS=101, line_even=0; end of line 311 -> (0,0) with frame_start=1 for one clock; frame period 159744 clocks.
- Line 1 -> sync=0 for cntHS 0..217 and 256..473; line 310 -> sync=0 for 0..18 and 256..274; line 4 same EQ pattern; line_visible=0 on all three.
- vblank -> 1 on lines 0..39 and 296..311, 0 on lines 40..295; line_visible never 1 when vblank=1.
- Async reset asserted mid-line (cntVS=150, cntHS=300), not clock-aligned -> outputs return to reset values without waiting for a clock edge; after release, the sequence matches the power-on run cycle-for-cycle.
